knn_topk_collector: RTL and testbench
=====================================

Name: knn_topk_collector

Overview:
- Sits downstream of the squared-distance unit; consumes its stream of (distance_sq, vertex_id) results for one query.
- Keeps the K smallest distances in a sorted register list.
- After the query's last vertex, emits the K nearest vertices in ascending distance order as a valid/last stream to the query-result logic.
- Provides the nearest-neighbour stage of the search pipeline.

Parameters:
- K, 4, number of nearest neighbours kept (1..16).
- ID_W, 16, width of the vertex identifier.
- DIST_W, 32, width of the squared distance, unsigned.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  one-cycle pulse: clear list and begin a new query
- data_valid_in  input  1  distance_sq_in/vertex_id_in/last_in valid this cycle
- distance_sq_in  input  DIST_W  squared distance of the candidate vertex (unsigned)
- vertex_id_in  input  ID_W  identifier of the candidate vertex
- last_in  input  1  qualifies the final candidate of the query
- ready_out  output  1  high only in COLLECT; candidates are accepted only when data_valid_in && ready_out
- result_valid_out  output  1  result entry valid
- result_dist_out  output  DIST_W  squared distance of the emitted entry
- result_id_out  output  ID_W  vertex id of the emitted entry
- result_last_out  output  1  final emitted entry of this query
- busy_out  output  1  high in COLLECT or EMIT

Behaviour:
- Reset: state IDLE; all outputs 0; fill count 0; list entries invalid.
- Reset has priority over everything, including mid-COLLECT or mid-EMIT: no further results are emitted.
- State machine:
  - IDLE → COLLECT on start_in.
  - COLLECT → EMIT on the cycle after an accepted candidate with last_in=1.
  - EMIT → IDLE after the entry with result_last_out is emitted.
- start_in in COLLECT: list and count are cleared; the query restarts; any candidate in the same cycle is dropped.
- start_in in EMIT or in the last-emit cycle: ignored.
- data_valid_in outside COLLECT: ignored.
- Insertion: one candidate per cycle, no stall; ready_out stays high throughout COLLECT.
  - The new candidate's position is the number of valid entries with dist <= candidate (unsigned compare).
  - Entries at and after that position shift down by one; entry K-1 is discarded.
  - If position == K (list full and candidate >= every entry), the candidate is dropped.
  - Ties: the earlier-arrived entry stays ahead of the new one.
  - Fill count saturates at K.
- Emission:
  - result_valid_out first rises 2 cycles after the clock edge that accepted last_in.
  - One entry per cycle, consecutive, index 0 (smallest) first.
  - Number of entries emitted = fill count (1..K).
  - result_last_out is high with the final entry only.
  - No backpressure on the result stream.
- All outputs are registered.
- result_dist_out and result_id_out hold their last value when result_valid_out=0.

Test Plan:
- K=4. start; candidates (dist,id) = (50,1) (10,2) (30,3) (20,4) (40,5, last) → results (10,2) (20,4) (30,3) (40,5), last on the 4th; first valid at last-accept+2; busy_out drops after emit.
- start; candidates (7,1) (3,2, last) → exactly 2 results: (3,2) then (7,1, last); fill count 2.
- Ties: (5,9) (5,8) (5,7) (5,6) (5,5, last) → ids 9, 8, 7, 6; id 5 is dropped.
- start; 3 candidates; start again; then (100,1, last) → single result (100,1, last); earlier candidates absent.
- rst_in asserted during EMIT after the 2nd result → result_valid_out=0 the next cycle; state IDLE; data_valid_in ignored until start_in.
- Max value: candidate 0xFFFFFFFF alongside 0x00000000 → unsigned order: 0x00000000 first.
- Candidate with data_valid_in=1 in IDLE → no effect; a subsequent query result is unaffected.

Source files
------------

// File: rtl/knn_topk_collector.sv
// K-nearest collector: keeps the K smallest (distance, id) pairs of a query in a
// sorted register list and streams them out in ascending order after the last candidate.
module knn_topk_collector #(
  parameter int unsigned K      = 4,
  parameter int unsigned ID_W   = 16,
  parameter int unsigned DIST_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  input  logic              data_valid_in,
  input  logic [DIST_W-1:0] distance_sq_in,
  input  logic [ID_W-1:0]   vertex_id_in,
  input  logic              last_in,
  output logic              ready_out,
  output logic              result_valid_out,
  output logic [DIST_W-1:0] result_dist_out,
  output logic [ID_W-1:0]   result_id_out,
  output logic              result_last_out,
  output logic              busy_out
);

  localparam int unsigned CNT_W = $clog2(K + 1);
  localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  fill_cnt, fill_nxt;
  logic [DIST_W-1:0] list_dist [K];
  logic [DIST_W-1:0] list_dist_nxt [K];
  logic [ID_W-1:0]   list_id [K];
  logic [ID_W-1:0]   list_id_nxt [K];
  logic [IDX_W-1:0]  emit_idx, emit_idx_nxt;

  // Read stage between the list and the output registers.
  logic              sel_valid, sel_valid_nxt;
  logic              sel_last, sel_last_nxt;
  logic [DIST_W-1:0] sel_dist, sel_dist_nxt;
  logic [ID_W-1:0]   sel_id, sel_id_nxt;

  logic              ready_nxt, busy_nxt;
  logic              res_valid_nxt, res_last_nxt;
  logic [DIST_W-1:0] res_dist_nxt;
  logic [ID_W-1:0]   res_id_nxt;

  logic [CNT_W-1:0]  ins_pos;
  logic [DIST_W-1:0] shift_dist [K];
  logic [ID_W-1:0]   shift_id [K];

  // Next-state, list update and output computation.
  always_comb begin
    state_nxt     = state;
    fill_nxt      = fill_cnt;
    list_dist_nxt = list_dist;
    list_id_nxt   = list_id;
    emit_idx_nxt  = emit_idx;
    sel_valid_nxt = 1'b0;
    sel_last_nxt  = 1'b0;
    sel_dist_nxt  = sel_dist;
    sel_id_nxt    = sel_id;
    ins_pos       = '0;

    // Insertion point: count of valid entries not greater than the candidate (keeps ties stable).
    for (int i = 0; i < int'(K); i++) begin
      if ((CNT_W'(i) < fill_cnt) && (list_dist[i] <= distance_sq_in))
        ins_pos = ins_pos + CNT_W'(1);
    end

    shift_dist[0] = list_dist[0];
    shift_id[0]   = list_id[0];
    for (int i = 1; i < int'(K); i++) begin
      shift_dist[i] = list_dist[i-1];
      shift_id[i]   = list_id[i-1];
    end

    case (state)
      S_IDLE: begin
        // The cycle showing the final result still counts as emission: start is ignored there.
        if (start_in && !result_last_out) begin
          state_nxt = S_COLLECT;
          fill_nxt  = '0;
        end
      end
      S_COLLECT: begin
        if (start_in) begin
          fill_nxt = '0;
        end else if (data_valid_in) begin
          if (ins_pos < CNT_W'(K)) begin
            for (int i = 0; i < int'(K); i++) begin
              if (CNT_W'(i) == ins_pos) begin
                list_dist_nxt[i] = distance_sq_in;
                list_id_nxt[i]   = vertex_id_in;
              end else if (CNT_W'(i) > ins_pos) begin
                list_dist_nxt[i] = shift_dist[i];
                list_id_nxt[i]   = shift_id[i];
              end
            end
            if (fill_cnt < CNT_W'(K))
              fill_nxt = fill_cnt + CNT_W'(1);
          end
          if (last_in) begin
            state_nxt    = S_EMIT;
            emit_idx_nxt = '0;
          end
        end
      end
      S_EMIT: begin
        if (sel_last) begin
          state_nxt = S_IDLE;
        end else begin
          sel_valid_nxt = 1'b1;
          sel_dist_nxt  = list_dist[emit_idx];
          sel_id_nxt    = list_id[emit_idx];
          sel_last_nxt  = (CNT_W'(emit_idx) == (fill_cnt - CNT_W'(1)));
          emit_idx_nxt  = emit_idx + IDX_W'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    ready_nxt     = (state_nxt == S_COLLECT);
    busy_nxt      = (state_nxt != S_IDLE);
    res_valid_nxt = sel_valid;
    res_last_nxt  = sel_last;
    res_dist_nxt  = sel_valid ? sel_dist : result_dist_out;
    res_id_nxt    = sel_valid ? sel_id : result_id_out;
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= S_IDLE;
      fill_cnt         <= '0;
      emit_idx         <= '0;
      sel_valid        <= 1'b0;
      sel_last         <= 1'b0;
      sel_dist         <= '0;
      sel_id           <= '0;
      ready_out        <= 1'b0;
      busy_out         <= 1'b0;
      result_valid_out <= 1'b0;
      result_last_out  <= 1'b0;
      result_dist_out  <= '0;
      result_id_out    <= '0;
      for (int i = 0; i < int'(K); i++) begin
        list_dist[i] <= '0;
        list_id[i]   <= '0;
      end
    end else begin
      state            <= state_nxt;
      fill_cnt         <= fill_nxt;
      emit_idx         <= emit_idx_nxt;
      sel_valid        <= sel_valid_nxt;
      sel_last         <= sel_last_nxt;
      sel_dist         <= sel_dist_nxt;
      sel_id           <= sel_id_nxt;
      ready_out        <= ready_nxt;
      busy_out         <= busy_nxt;
      result_valid_out <= res_valid_nxt;
      result_last_out  <= res_last_nxt;
      result_dist_out  <= res_dist_nxt;
      result_id_out    <= res_id_nxt;
      for (int i = 0; i < int'(K); i++) begin
        list_dist[i] <= list_dist_nxt[i];
        list_id[i]   <= list_id_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_knn_topk_collector.sv
// Directed bench for knn_topk_collector (K=4): ordering, fill count, ties, restart, reset, IDLE input.
module tb_knn_topk_collector;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        data_valid_in;
  logic [31:0] distance_sq_in;
  logic [15:0] vertex_id_in;
  logic        last_in;
  logic        ready_out;
  logic        result_valid_out;
  logic [31:0] result_dist_out;
  logic [15:0] result_id_out;
  logic        result_last_out;
  logic        busy_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_d  [16];
  logic [15:0] exp_id [16];

  knn_topk_collector #(.K(4), .ID_W(16), .DIST_W(32)) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .start_in         (start_in),
    .data_valid_in    (data_valid_in),
    .distance_sq_in   (distance_sq_in),
    .vertex_id_in     (vertex_id_in),
    .last_in          (last_in),
    .ready_out        (ready_out),
    .result_valid_out (result_valid_out),
    .result_dist_out  (result_dist_out),
    .result_id_out    (result_id_out),
    .result_last_out  (result_last_out),
    .busy_out         (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    @(negedge clk_in);
    start_in = 1'b1; data_valid_in = 1'b0; last_in = 1'b0;
    @(negedge clk_in);
    start_in = 1'b0;
    check("start_ready", 64'(ready_out), 64'd1);
    check("start_busy", 64'(busy_out), 64'd1);
  endtask

  // Presents one candidate; the next negedge (any later call) ends it.
  task automatic send(input logic [31:0] d, input logic [15:0] id, input logic lst);
    @(negedge clk_in);
    start_in = 1'b0; data_valid_in = 1'b1;
    distance_sq_in = d; vertex_id_in = id; last_in = lst;
  endtask

  // Expects n results starting exactly two edges after the last_in accept.
  task automatic collect(input int n);
    @(negedge clk_in);
    data_valid_in = 1'b0; last_in = 1'b0;
    check("lat_e1", 64'(result_valid_out), 64'd0);
    check("emit_ready_low", 64'(ready_out), 64'd0);
    @(negedge clk_in);
    check("lat_e2", 64'(result_valid_out), 64'd0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      check($sformatf("res%0d_valid", k), 64'(result_valid_out), 64'd1);
      check($sformatf("res%0d_dist", k), 64'(result_dist_out), 64'(exp_d[k]));
      check($sformatf("res%0d_id", k), 64'(result_id_out), 64'(exp_id[k]));
      check($sformatf("res%0d_last", k), 64'(result_last_out), 64'(k == n - 1));
    end
    @(negedge clk_in);
    check("post_valid", 64'(result_valid_out), 64'd0);
    check("post_busy", 64'(busy_out), 64'd0);
    check("post_hold_dist", 64'(result_dist_out), 64'(exp_d[n-1]));
  endtask

  initial begin
    rst_in = 1'b1; start_in = 1'b0; data_valid_in = 1'b0;
    distance_sq_in = '0; vertex_id_in = '0; last_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst_ready", 64'(ready_out), 64'd0);
    check("rst_valid", 64'(result_valid_out), 64'd0);
    check("rst_busy", 64'(busy_out), 64'd0);
    check("rst_dist", 64'(result_dist_out), 64'd0);
    check("rst_last", 64'(result_last_out), 64'd0);
    rst_in = 1'b0;

    // Sorting with eviction of the largest entry.
    do_start();
    send(50, 1, 0); send(10, 2, 0); send(30, 3, 0); send(20, 4, 0); send(40, 5, 1);
    exp_d[0] = 10; exp_id[0] = 2; exp_d[1] = 20; exp_id[1] = 4;
    exp_d[2] = 30; exp_id[2] = 3; exp_d[3] = 40; exp_id[3] = 5;
    collect(4);

    // Partial fill: only two results.
    do_start();
    send(7, 1, 0); send(3, 2, 1);
    exp_d[0] = 3; exp_id[0] = 2; exp_d[1] = 7; exp_id[1] = 1;
    collect(2);

    // Ties keep arrival order; the fifth equal candidate is dropped.
    do_start();
    send(5, 9, 0); send(5, 8, 0); send(5, 7, 0); send(5, 6, 0); send(5, 5, 1);
    for (int k = 0; k < 4; k++) begin
      exp_d[k] = 5; exp_id[k] = 16'(9 - k);
    end
    collect(4);

    // Restart mid-collect; candidate coinciding with start is dropped.
    do_start();
    send(1, 11, 0); send(2, 12, 0); send(3, 13, 0);
    @(negedge clk_in);
    start_in = 1'b1; data_valid_in = 1'b1; distance_sq_in = 0; vertex_id_in = 99; last_in = 1'b0;
    send(100, 1, 1);
    exp_d[0] = 100; exp_id[0] = 1;
    collect(1);

    // Reset during emission after the second result.
    do_start();
    send(4, 1, 0); send(3, 2, 0); send(2, 3, 0); send(1, 4, 1);
    @(negedge clk_in);
    data_valid_in = 1'b0; last_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_mid_res1_id", 64'(result_id_out), 64'd3);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_mid_valid", 64'(result_valid_out), 64'd0);
    check("rst_mid_busy", 64'(busy_out), 64'd0);
    check("rst_mid_ready", 64'(ready_out), 64'd0);
    send(8, 8, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      data_valid_in = 1'b0; last_in = 1'b0;
      check("rst_idle_valid", 64'(result_valid_out), 64'd0);
      check("rst_idle_busy", 64'(busy_out), 64'd0);
    end

    // Unsigned extremes.
    do_start();
    send(32'hFFFF_FFFF, 1, 0); send(32'h0000_0000, 2, 1);
    exp_d[0] = 32'h0; exp_id[0] = 2; exp_d[1] = 32'hFFFF_FFFF; exp_id[1] = 1;
    collect(2);

    // Candidate in IDLE has no effect on the next query.
    send(1, 77, 1);
    @(negedge clk_in);
    data_valid_in = 1'b0; last_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("idle_cand_valid", 64'(result_valid_out), 64'd0);
    check("idle_cand_ready", 64'(ready_out), 64'd0);
    do_start();
    send(9, 3, 0); send(4, 4, 1);
    exp_d[0] = 4; exp_id[0] = 4; exp_d[1] = 9; exp_id[1] = 3;
    collect(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
